// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state type and a small op classification helper.
package mdu_iter_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_t;

    // True for the ops that treat their operands as two's complement.
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_iter_shift_engine.sv
// One-bit-per-cycle datapath shared by multiply and divide.
// The 2*WIDTH accumulator holds {partial product, multiplier} for a multiply
// and {remainder, dividend/quotient} for a divide; both start as {0, init}.
module mdu_iter_shift_engine
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 div_mode,
    input  logic [WIDTH-1:0]     init,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc
);

    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       rem_diff;
    logic [WIDTH-1:0]     rem_next;
    logic                 quot_bit;
    logic [2*WIDTH-1:0]   acc_next;

    // Next accumulator value: shift-add for multiply, restoring shift-subtract for divide.
    // The remainder stays below the divisor, so the borrow bit of the trial
    // subtraction alone tells whether the subtraction succeeds.
    always_comb begin
        add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, operand};
        quot_bit  = ~rem_diff[WIDTH];
        rem_next  = quot_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        if (div_mode) begin
            acc_next = {rem_next, acc[WIDTH-2:0], quot_bit};
        end else begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
        end
    end

    // Accumulator register: loaded when an op launches, advanced once per iteration.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            acc <= '0;
        end else if (load) begin
            acc <= {{WIDTH{1'b0}}, init};
        end else if (step) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operands are reduced to magnitudes on launch, iterated one bit per clock
// in the shift engine, and the signs are reapplied in a single FIX cycle.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    output logic              Busy,
    output logic              Done,
    output logic              DivByZero,
    output logic [WIDTH-1:0]  Hi,
    output logic [WIDTH-1:0]  Lo
);

    localparam int CNTW = $clog2(WIDTH + 1);
    localparam logic [CNTW-1:0] LAST_ITER = CNTW'(WIDTH - 1);

    mdu_state_t           state;
    logic [CNTW-1:0]      count;
    logic                 div_mode;
    logic                 neg_a;
    logic                 neg_b;
    logic                 zero_div;
    logic [WIDTH-1:0]     operand;

    logic                 is_mult;
    logic                 is_div;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 accept;
    logic                 launch;
    logic                 div_by_zero_req;
    logic [WIDTH-1:0]     load_value;

    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    // Decode the request and form operand magnitudes for a possible launch.
    always_comb begin
        is_mult         = (Op == MDU_MULT) || (Op == MDU_MULTU);
        is_div          = (Op == MDU_DIV) || (Op == MDU_DIVU);
        sign_a          = op_is_signed(Op) && A[WIDTH-1];
        sign_b          = op_is_signed(Op) && B[WIDTH-1];
        mag_a           = sign_a ? -A : A;
        mag_b           = sign_b ? -B : B;
        accept          = Start && (state == MDU_IDLE);
        launch          = accept && (is_mult || is_div);
        div_by_zero_req = is_div && (B == '0);
        load_value      = is_div ? mag_a : mag_b;
    end

    mdu_iter_shift_engine #(.WIDTH(WIDTH)) u_engine (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (launch),
        .step     (state == MDU_CALC),
        .div_mode (div_mode),
        .init     (load_value),
        .operand  (operand),
        .acc      (acc)
    );

    // Sign correction of the finished magnitude result. On a zero divisor the
    // engine never stepped, so its low half still holds |A| and re-signing it
    // recovers the original dividend for HI.
    always_comb begin
        product   = (neg_a ^ neg_b) ? -acc : acc;
        quotient  = acc[WIDTH-1:0];
        remainder = acc[2*WIDTH-1:WIDTH];
        if (zero_div) begin
            fix_hi = neg_a ? -quotient : quotient;
            fix_lo = '1;
        end else if (div_mode) begin
            fix_hi = neg_a ? -remainder : remainder;
            fix_lo = (neg_a ^ neg_b) ? -quotient : quotient;
        end else begin
            fix_hi = product[2*WIDTH-1:WIDTH];
            fix_lo = product[WIDTH-1:0];
        end
    end

    // Control FSM: accepts requests in IDLE, counts iterations in CALC and
    // commits the corrected result to HI/LO in FIX with a one-cycle Done pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= MDU_IDLE;
            count     <= '0;
            div_mode  <= 1'b0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            zero_div  <= 1'b0;
            operand   <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
        end else begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            case (state)
                MDU_IDLE: begin
                    if (accept && (Op == MDU_MTHI)) begin
                        Hi <= A;
                    end else if (accept && (Op == MDU_MTLO)) begin
                        Lo <= A;
                    end else if (launch) begin
                        div_mode <= is_div;
                        neg_a    <= sign_a;
                        neg_b    <= sign_b;
                        operand  <= is_div ? mag_b : mag_a;
                        count    <= '0;
                        zero_div <= div_by_zero_req;
                        Busy     <= 1'b1;
                        state    <= div_by_zero_req ? MDU_FIX : MDU_CALC;
                    end
                end
                MDU_CALC: begin
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state <= MDU_FIX;
                    end
                end
                MDU_FIX: begin
                    Hi        <= fix_hi;
                    Lo        <= fix_lo;
                    Busy      <= 1'b0;
                    Done      <= 1'b1;
                    DivByZero <= zero_div;
                    state     <= MDU_IDLE;
                end
                default: begin
                    state <= MDU_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter at WIDTH=32 and WIDTH=16.
// Stimulus pushes expected HI/LO/DivByZero into a per-instance queue; a
// monitor on each instance pops and compares whenever Done is seen.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset;

    logic        start32, start16;
    logic [2:0]  op32, op16;
    logic [31:0] a32, b32;
    logic [15:0] a16, b16;
    logic        busy32, done32, dbz32;
    logic        busy16, done16, dbz16;
    logic [31:0] hi32, lo32;
    logic [15:0] hi16, lo16;

    exp_t        q32[$];
    exp_t        q16[$];
    int          checks = 0;
    int          errors = 0;

    always #5 Clock = ~Clock;

    mdu_iter #(.WIDTH(32)) dut32 (
        .Clock(Clock), .Reset(Reset), .Start(start32), .Op(op32), .A(a32), .B(b32),
        .Busy(busy32), .Done(done32), .DivByZero(dbz32), .Hi(hi32), .Lo(lo32)
    );

    mdu_iter #(.WIDTH(16)) dut16 (
        .Clock(Clock), .Reset(Reset), .Start(start16), .Op(op16), .A(a16), .B(b16),
        .Busy(busy16), .Done(done16), .DivByZero(dbz16), .Hi(hi16), .Lo(lo16)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor for the 32-bit instance: every Done must match the oldest expectation.
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset && done32) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL w32_unexpected_done: got Done=1 with no pending operation");
            end else begin
                e = q32.pop_front();
                checkOutput("w32_hi", hi32, e.hi);
                checkOutput("w32_lo", lo32, e.lo);
                checkOutput("w32_dbz", {31'd0, dbz32}, {31'd0, e.dbz});
                checkOutput("w32_busy_at_done", {31'd0, busy32}, 32'd0);
            end
        end
    end

    // Monitor for the 16-bit instance.
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset && done16) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL w16_unexpected_done: got Done=1 with no pending operation");
            end else begin
                e = q16.pop_front();
                checkOutput("w16_hi", {16'd0, hi16}, e.hi);
                checkOutput("w16_lo", {16'd0, lo16}, e.lo);
                checkOutput("w16_dbz", {31'd0, dbz16}, {31'd0, e.dbz});
            end
        end
    end

    task automatic driveInputs(input bit narrow, input logic start, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b);
        if (narrow) begin
            start16 = start; op16 = op; a16 = a[15:0]; b16 = b[15:0];
        end else begin
            start32 = start; op32 = op; a32 = a; b32 = b;
        end
    endtask

    // Waits (bounded) for Done after the sampling edge, counting edges and Busy cycles.
    task automatic waitDone(input bit narrow, output int edges, output int busy_cycles, output bit seen);
        edges       = 0;
        seen        = 0;
        busy_cycles = (narrow ? busy16 : busy32) ? 1 : 0;
        while (!seen && edges < 100) begin
            @(posedge Clock);
            #1;
            edges++;
            if (narrow ? busy16 : busy32) busy_cycles++;
            if (narrow ? done16 : done32) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no Done within %0d edges, expected one", edges);
        end
    endtask

    task automatic applyStimulus(input bit narrow, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp_hi,
                                 input logic [31:0] exp_lo, input logic exp_dbz,
                                 input int exp_lat, input string name);
        exp_t e;
        int   edges, busy_cycles;
        bit   seen;
        e.hi = exp_hi; e.lo = exp_lo; e.dbz = exp_dbz;
        if (narrow) q16.push_back(e); else q32.push_back(e);
        @(negedge Clock);
        driveInputs(narrow, 1'b1, op, a, b);
        @(posedge Clock);
        #1;
        driveInputs(narrow, 1'b0, op, a, b);
        waitDone(narrow, edges, busy_cycles, seen);
        if (seen) begin
            checkOutput({name, "_latency"}, edges, exp_lat);
            checkOutput({name, "_busy_cycles"}, busy_cycles, exp_lat);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        exp_t e;
        int   edges, busy_cycles;
        bit   seen;

        Reset = 1'b1;
        driveInputs(1'b0, 1'b0, MDU_MULT, 32'd0, 32'd0);
        driveInputs(1'b1, 1'b0, MDU_MULT, 32'd0, 32'd0);
        repeat (3) @(posedge Clock);
        #1;
        checkOutput("reset_busy", {31'd0, busy32}, 32'd0);
        checkOutput("reset_done", {31'd0, done32}, 32'd0);
        checkOutput("reset_dbz", {31'd0, dbz32}, 32'd0);
        checkOutput("reset_hi", hi32, 32'd0);
        checkOutput("reset_lo", lo32, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;

        $display("[TB] WIDTH=32 arithmetic vectors");
        applyStimulus(0, MDU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0, 33, "mult_neg3x7");
        applyStimulus(0, MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 33, "multu_max");
        applyStimulus(0, MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0, 33, "mult_m1xm1");
        applyStimulus(0, MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33, "div_neg7by2");
        applyStimulus(0, MDU_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        0, 33, "divu_7by2");
        applyStimulus(0, MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 0, 33, "div_minbym1");
        applyStimulus(0, MDU_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1, 1,  "divu_by0");
        @(posedge Clock);
        #1;
        checkOutput("dbz_pulse_end", {31'd0, dbz32}, 32'd0);
        checkOutput("done_pulse_end", {31'd0, done32}, 32'd0);

        $display("[TB] Start while busy is ignored");
        e.hi = 32'd0; e.lo = 32'd300; e.dbz = 1'b0;
        q32.push_back(e);
        @(negedge Clock);
        driveInputs(0, 1'b1, MDU_MULT, 32'd100, 32'd3);
        @(posedge Clock);
        #1;
        driveInputs(0, 1'b0, MDU_MULT, 32'd100, 32'd3);
        repeat (5) @(posedge Clock);
        #1;
        driveInputs(0, 1'b1, MDU_MTHI, 32'h1234, 32'd0);
        @(posedge Clock);
        #1;
        driveInputs(0, 1'b1, MDU_DIV, 32'd50, 32'd5);
        @(posedge Clock);
        #1;
        driveInputs(0, 1'b0, MDU_DIV, 32'd50, 32'd5);
        waitDone(0, edges, busy_cycles, seen);
        repeat (3) @(posedge Clock);
        #1;
        checkOutput("ignored_busy", {31'd0, busy32}, 32'd0);
        checkOutput("ignored_hi", hi32, 32'd0);
        checkOutput("ignored_lo", lo32, 32'd300);

        @(negedge Clock);
        driveInputs(0, 1'b1, MDU_MTLO, 32'hABCD, 32'd0);
        @(posedge Clock);
        #1;
        driveInputs(0, 1'b0, MDU_MTLO, 32'hABCD, 32'd0);
        checkOutput("mtlo_lo", lo32, 32'hABCD);
        checkOutput("mtlo_hi", hi32, 32'd0);
        checkOutput("mtlo_busy", {31'd0, busy32}, 32'd0);
        checkOutput("mtlo_done", {31'd0, done32}, 32'd0);

        $display("[TB] WIDTH=16 arithmetic vectors");
        applyStimulus(1, MDU_MULT,  32'hFFFD, 32'd7,    32'hFFFF, 32'hFFEB, 0, 17, "w16_mult_neg3x7");
        applyStimulus(1, MDU_MULTU, 32'hFFFF, 32'hFFFF, 32'hFFFE, 32'h0001, 0, 17, "w16_multu_max");
        applyStimulus(1, MDU_MULT,  32'hFFFF, 32'hFFFF, 32'h0000, 32'h0001, 0, 17, "w16_mult_m1xm1");
        applyStimulus(1, MDU_DIV,   32'hFFF9, 32'd2,    32'hFFFF, 32'hFFFD, 0, 17, "w16_div_neg7by2");
        applyStimulus(1, MDU_DIVU,  32'd7,    32'd2,    32'd1,    32'd3,    0, 17, "w16_divu_7by2");
        applyStimulus(1, MDU_DIV,   32'h8000, 32'hFFFF, 32'd0,    32'h8000, 0, 17, "w16_div_minbym1");

        $display("[TB] Reset in the middle of a divide");
        @(negedge Clock);
        driveInputs(0, 1'b1, MDU_DIV, 32'd100, 32'd7);
        @(posedge Clock);
        #1;
        driveInputs(0, 1'b0, MDU_DIV, 32'd100, 32'd7);
        repeat (10) @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        checkOutput("midreset_busy", {31'd0, busy32}, 32'd0);
        checkOutput("midreset_done", {31'd0, done32}, 32'd0);
        checkOutput("midreset_hi", hi32, 32'd0);
        checkOutput("midreset_lo", lo32, 32'd0);
        Reset = 1'b0;
        applyStimulus(0, MDU_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 0, 33, "mult_6x7_after_reset");

        repeat (3) @(posedge Clock);
        #1;
        checks++;
        if (q32.size() != 0 || q16.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_results: got %0d/%0d unserved, expected 0/0", q32.size(), q16.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
